tt_wb_sel_ctrl: RTL and testbench

TT_WB_SEL_CTRL -- requirements
Module: tt_wb_sel_ctrl

---
 rtl/tt_sel_pkg.sv | 26 ++
 rtl/tt_pulse_timer.sv | 30 +++
 rtl/tt_wb_sel_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_tt_wb_sel_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sel_pkg.sv
// Shared definitions for the Wishbone design-select controller.
// Holds the sequencer state encoding, the register window offsets and the
// STATUS register bit positions used by both the RTL and anyone decoding it.
package tt_sel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_REL,
    ST_INC_H,
    ST_INC_L,
    ST_DONE
  } sel_state_t;

  // Register offsets inside the 16-byte window
  localparam logic [3:0] OFF_SEL    = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_ENA    = 4'h8;

  // STATUS register layout
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ERR     = 2;
  localparam int unsigned STAT_CUR_LSB = 16;

endpackage

// File: rtl/tt_pulse_timer.sv
// Phase timer shared by every timed state of the select sequencer.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   load   - restart the phase; the following PULSE_W cycles form one phase
//   expire - high in the last cycle of the current phase
module tt_pulse_timer #(
  parameter int unsigned PULSE_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 4'(PULSE_W - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/tt_wb_sel_ctrl.sv
// Wishbone-controlled design-select sequencer.
// A write to SEL resets the downstream select counter and then pulses its
// increment input once per target step; STATUS reports progress and sticky
// done/error flags, ENA gates the selected design while no sequence runs.
// Ports:
//   wb_clk_i, wb_rst_i          - clock and synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i  - Wishbone classic control (sel ignored)
//   wbs_adr_i, wbs_dat_i        - address and write data
//   wbs_ack_o, wbs_dat_o        - one-cycle acknowledge and read data
//   ctrl_sel_rst_n, ctrl_sel_inc - downstream select counter reset / increment
//   ctrl_ena                    - enable of the selected design
//   irq_o                       - one-cycle pulse at sequence completion
module tt_wb_sel_ctrl
  import tt_sel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned PULSE_W   = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ctrl_sel_rst_n,
  output logic        ctrl_sel_inc,
  output logic        ctrl_ena,
  output logic        irq_o
);

  sel_state_t        state;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [ADDR_W-1:0] current_q;
  logic              sel_rst_n_q;
  logic              sel_inc_q;
  logic              irq_q;

  logic              ack_q;
  logic [31:0]       dat_q;
  logic              ena_q;
  logic              done_q;
  logic              err_q;

  logic              hit;
  logic              accept;
  logic [3:0]        off;
  logic              busy;
  logic              sel_wr;
  logic              sel_start;
  logic              sel_reject;
  logic              status_wr;
  logic              ena_wr;
  logic [31:0]       rd_word;
  logic              tmr_load;
  logic              tmr_expire;
  logic              unused_ok;

  assign unused_ok = &{1'b0, wbs_sel_i, wbs_dat_i};

  assign off        = wbs_adr_i[3:0];
  assign hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept     = wbs_stb_i & wbs_cyc_i & ~ack_q & hit;
  assign busy       = (state != ST_IDLE);
  assign sel_wr     = accept & wbs_we_i & (off == OFF_SEL);
  assign sel_start  = sel_wr & ~busy;
  assign sel_reject = sel_wr & busy;
  assign status_wr  = accept & wbs_we_i & (off == OFF_STATUS);
  assign ena_wr     = accept & wbs_we_i & (off == OFF_ENA);

  // Every timed state restarts the timer on its way in, so one counter
  // serves the whole sequence.
  assign tmr_load = sel_start |
                    (tmr_expire & (state inside {ST_RST, ST_REL, ST_INC_H, ST_INC_L}));

  tt_pulse_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      target_q    <= '0;
      remaining_q <= '0;
      current_q   <= '0;
      sel_rst_n_q <= 1'b0;
      sel_inc_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sel_rst_n_q <= 1'b1;
          sel_inc_q   <= 1'b0;
          irq_q       <= 1'b0;
          if (sel_start) begin
            target_q    <= wbs_dat_i[ADDR_W-1:0];
            remaining_q <= wbs_dat_i[ADDR_W-1:0];
            current_q   <= '0;
            sel_rst_n_q <= 1'b0;
            state       <= ST_RST;
          end
        end
        ST_RST: begin
          if (tmr_expire) begin
            sel_rst_n_q <= 1'b1;
            state       <= ST_REL;
          end
        end
        ST_REL: begin
          if (tmr_expire) begin
            if (remaining_q != '0) begin
              sel_inc_q <= 1'b1;
              state     <= ST_INC_H;
            end else begin
              irq_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_INC_H: begin
          if (tmr_expire) begin
            sel_inc_q <= 1'b0;
            state     <= ST_INC_L;
          end
        end
        ST_INC_L: begin
          if (tmr_expire) begin
            remaining_q <= remaining_q - 1'b1;
            current_q   <= current_q + 1'b1;
            // Decision uses the pre-decrement count: one step left means done.
            if (remaining_q != ADDR_W'(1)) begin
              sel_inc_q <= 1'b1;
              state     <= ST_INC_H;
            end else begin
              irq_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          irq_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (off)
      OFF_SEL: rd_word[ADDR_W-1:0] = target_q;
      OFF_STATUS: begin
        rd_word[STAT_BUSY]                = busy;
        rd_word[STAT_DONE]                = done_q;
        rd_word[STAT_ERR]                 = err_q;
        rd_word[STAT_CUR_LSB +: ADDR_W]   = current_q;
      end
      OFF_ENA: rd_word[0] = ena_q;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      ena_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept & ~wbs_we_i) ? rd_word : '0;
      if (ena_wr) ena_q <= wbs_dat_i[0];
      if (status_wr & wbs_dat_i[STAT_DONE]) done_q <= 1'b0;
      if (status_wr & wbs_dat_i[STAT_ERR])  err_q  <= 1'b0;
      // Sets come last so they win over a same-cycle clear.
      if (state == ST_DONE) done_q <= 1'b1;
      if (sel_reject)       err_q  <= 1'b1;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = sel_inc_q;
  assign ctrl_ena       = ena_q & ~busy;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_tt_wb_sel_ctrl.sv
// Self-checking bench for tt_wb_sel_ctrl with PULSE_W=2, ADDR_W=9.
module tb_tt_wb_sel_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int unsigned AW   = 9;
  localparam int          P    = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        stb   = 1'b0;
  logic        cyc   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  bsel  = 4'hF;
  logic [31:0] adr   = '0;
  logic [31:0] wdat  = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        sel_rst_n;
  logic        sel_inc;
  logic        ctrl_ena;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model of the register-visible state
  logic ena_m  = 1'b0;
  logic done_m = 1'b0;
  logic err_m  = 1'b0;
  int   cur_m  = 0;
  int   last_m = 0;

  tt_wb_sel_ctrl #(
    .BASE_ADDR (BASE),
    .ADDR_W    (AW),
    .PULSE_W   (P)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wbs_stb_i      (stb),
    .wbs_cyc_i      (cyc),
    .wbs_we_i       (we),
    .wbs_sel_i      (bsel),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (wdat),
    .wbs_ack_o      (ack),
    .wbs_dat_o      (rdata),
    .ctrl_sel_rst_n (sel_rst_n),
    .ctrl_sel_inc   (sel_inc),
    .ctrl_ena       (ctrl_ena),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] status_exp();
    return (32'(cur_m) << 16) | (32'(err_m) << 2) | (32'(done_m) << 1);
  endfunction

  // Expected {rst_n, inc, irq, ena} k cycles after the SEL ack cycle began.
  function automatic logic [3:0] seq_exp(input int k, input int t);
    int   l;
    logic rn, inc, ie, en;
    l  = 2 * P * (t + 1) + 1;
    rn = (k >= P);
    inc = (k >= 2 * P) && (k < 2 * P * (t + 1)) && (((k - 2 * P) % (2 * P)) < P);
    ie = (k == l - 1);
    en = (k >= l) ? ena_m : 1'b0;
    return {rn, inc, ie, en};
  endfunction

  function automatic void inj_model(input logic [31:0] a, input logic [31:0] d);
    case (a[3:0])
      4'h0: err_m = 1'b1;
      4'h4: begin
        if (d[1]) done_m = 1'b0;
        if (d[2]) err_m  = 1'b0;
      end
      4'h8: ena_m = d[0];
      default: ;
    endcase
  endfunction

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] r);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    @(negedge clk);
    chk("ack_early", ack, 1'b0);
    chk("dat_idle", rdata, 32'h0);
    @(negedge clk);
    chk("ack", ack, 1'b1);
    r = rdata;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack_once", ack, 1'b0);
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    wb_access(1'b0, BASE + {28'h0, off}, 32'h0, r);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] r;
    wb_access(1'b1, BASE + {28'h0, off}, d, r);
  endtask

  // Write SEL=t and compare the control outputs every cycle until idle.
  // Optionally inject another write (issued after cycle inj) or assert
  // reset after cycle abort_at.
  task automatic sel_seq(input int t, input int inj, input logic [31:0] ia,
                         input logic [31:0] id, input int abort_at);
    int l;
    l = 2 * P * (t + 1) + 1;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; wdat = 32'(t);
    @(negedge clk);
    chk("sel_ack_early", ack, 1'b0);
    for (int k = 0; k <= l; k++) begin
      @(negedge clk);
      chk($sformatf("seq t=%0d k=%0d", t, k), {sel_rst_n, sel_inc, irq, ctrl_ena}, seq_exp(k, t));
      if (k == 0) begin
        chk("sel_ack", ack, 1'b1);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
      end
      if (k == abort_at) begin
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      if (inj > 0 && k == inj) begin
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = ia; wdat = id;
        inj_model(ia, id);
      end
      if (inj > 0 && k == inj + 2) begin
        chk("inj_ack", ack, 1'b1);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
      end
    end
    done_m = 1'b1;
    cur_m  = t;
    last_m = t;
  endtask

  initial begin
    int          t, l, inj, kind, abort_at;
    logic        b, seen;
    logic [31:0] ia, id;

    repeat (3) @(negedge clk);
    chk("reset_outs", {sel_rst_n, sel_inc, irq, ctrl_ena, ack}, 5'b0);
    chk("reset_dat", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release_rst_n", sel_rst_n, 1'b1);

    rd(4'h4, status_exp(), "status_init");
    rd(4'h0, 32'h0, "sel_init");
    rd(4'h8, 32'h0, "ena_init");

    // Basic sequences
    sel_seq(5, -1, '0, '0, -1);
    rd(4'h4, status_exp(), "status_sel5");
    sel_seq(0, -1, '0, '0, -1);
    rd(4'h4, status_exp(), "status_sel0");

    // Enable gating
    wr(4'h8, 32'h1);
    ena_m = 1'b1;
    rd(4'h8, 32'h1, "ena_rd");
    sel_seq(3, -1, '0, '0, -1);

    // SEL write while busy
    sel_seq(4, 7, BASE, 32'h1AB, -1);
    rd(4'h0, 32'd4, "sel_after_busy_wr");
    rd(4'h4, status_exp(), "status_err");
    wr(4'h4, 32'h4);
    err_m = 1'b0;
    rd(4'h4, status_exp(), "status_err_clr");

    // W1C of done landing in the DONE cycle
    l = 2 * P * 3 + 1;
    sel_seq(2, l - 2, BASE + 32'h4, 32'h2, -1);
    rd(4'h4, status_exp(), "status_done_race");

    // Address decode boundaries
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ack;
    end
    chk("miss_ack", seen, 1'b0);
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    rd(4'hC, 32'h0, "unmapped_rd");
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h0, 32'(last_m), "sel_after_unmapped_wr");

    // Randomized sequences with random side writes
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        b = 1'($urandom_range(0, 1));
        wr(4'h8, {31'h0, b});
        ena_m = b;
      end
      t    = $urandom_range(0, 12);
      l    = 2 * P * (t + 1) + 1;
      kind = $urandom_range(0, 3);
      inj  = -1;
      ia   = BASE;
      id   = $urandom;
      case (kind)
        1: ia = BASE;
        2: begin ia = BASE + 32'h4; id = id & 32'h6; end
        3: ia = BASE + 32'h8;
        default: ;
      endcase
      if (kind != 0) inj = $urandom_range(1, l - 2);
      sel_seq(t, inj, ia, id, -1);
      rd(4'h4, status_exp(), "status_rand");
      rd(4'h0, 32'(last_m), "sel_rand");
      rd(4'h8, {31'h0, ena_m}, "ena_rand");
      if (err_m && $urandom_range(0, 1) == 1) begin
        wr(4'h4, 32'h6);
        err_m  = 1'b0;
        done_m = 1'b0;
        rd(4'h4, status_exp(), "status_w1c_rand");
      end
    end

    // Reset during the third increment-high phase
    wr(4'h8, 32'h1);
    ena_m = 1'b1;
    t = $urandom_range(3, 8);
    abort_at = 6 * P - 1 + $urandom_range(0, P - 1);
    sel_seq(t, -1, '0, '0, abort_at);
    @(posedge clk);
    @(negedge clk);
    chk("abort_outs", {sel_rst_n, sel_inc, irq, ctrl_ena, ack}, 5'b0);
    chk("abort_dat", rdata, 32'h0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | irq;
    end
    chk("abort_no_irq", seen, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_release_rst_n", sel_rst_n, 1'b1);
    ena_m = 1'b0; done_m = 1'b0; err_m = 1'b0; cur_m = 0; last_m = 0;
    rd(4'h4, status_exp(), "status_after_abort");
    rd(4'h0, 32'h0, "sel_after_abort");
    rd(4'h8, 32'h0, "ena_after_abort");
    sel_seq(2, -1, '0, '0, -1);
    rd(4'h4, status_exp(), "status_after_abort_seq");

    // Largest target completes without wrapping
    sel_seq((1 << AW) - 1, -1, '0, '0, -1);
    rd(4'h4, status_exp(), "status_max");
    rd(4'h0, 32'((1 << AW) - 1), "sel_max");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
